// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// banked main-memory model (slave).
interface banked_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, data_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, data_valid, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank word memory, banks interleaved on addr[2:1]; a bank stays
// occupied BANK_BUSY cycles per access and reads return RD_LAT cycles later.
module bmr_bank_ctr #(
    parameter int             CNT_W    = 2,
    parameter logic [CNT_W-1:0] LOAD_VAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_cnt <= '0;
        else if (i_load)       r_cnt <= LOAD_VAL;
        else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_busy = (r_cnt != '0);
endmodule

module banked_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int BANK_BUSY = 4,
    parameter int RD_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    banked_mem_responder_if.slave bus
);
    localparam int NUM_BANKS = 4;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int CNT_W     = 2;

    logic [15:0]             r_mem [MEM_WORDS];
    logic [RD_LAT:1]         r_vld_pipe;
    logic [RD_LAT:1][15:0]   r_rd_pipe;

    logic [1:0]              w_bank;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_req, w_err, w_stall, w_acc, w_rd_acc, w_wr_acc;
    logic [NUM_BANKS-1:0]    w_busy, w_load;
    logic                    w_unused_addr;

    assign w_bank        = bus.addr[2:1];
    assign w_idx         = bus.addr[IDX_W:1];
    assign w_unused_addr = ^bus.addr[15:IDX_W+1];

    assign w_req    = bus.rd | bus.wr;
    assign w_err    = w_req & ((bus.rd & bus.wr) | bus.addr[0]);
    assign w_stall  = w_req & ~w_err & w_busy[w_bank];
    assign w_acc    = w_req & ~w_err & ~w_stall;
    assign w_rd_acc = w_acc & bus.rd;
    assign w_wr_acc = w_acc & bus.wr;

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            assign w_load[g] = w_acc && (w_bank == 2'(g));
            bmr_bank_ctr #(
                .CNT_W    (CNT_W),
                .LOAD_VAL (CNT_W'(BANK_BUSY - 1))
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load[g]),
                .o_busy (w_busy[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // Data rides along unconditionally; only the valid bit decides visibility.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_rd_pipe  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_LAT-1:1], w_rd_acc};
            r_rd_pipe  <= {r_rd_pipe[RD_LAT-1:1], r_mem[w_idx]};
        end
    end

    assign bus.data_valid = r_vld_pipe[RD_LAT];
    assign bus.data_out   = r_vld_pipe[RD_LAT] ? r_rd_pipe[RD_LAT] : 16'h0000;
    assign bus.stall      = w_stall;
    assign bus.err        = w_err;
    assign bus.busy       = w_busy;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench: scoreboard of expected read returns keyed by cycle, plus a
// small memory/bank-occupancy model for expected data and busy flags.
module tb_banked_mem_responder;
    logic clk;
    logic rst;
    banked_mem_responder_if bus ();

    banked_mem_responder #(.MEM_WORDS(256), .BANK_BUSY(4), .RD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [256];
    int          cnt_m [4];
    int          cycnt;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
        for (int b = 0; b < 4; b++) cnt_m[b] = 0;
        sb.delete();
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic exp_stall, input logic exp_err);
        logic [3:0] exp_busy;
        logic       acc;
        int         bk;
        int         idx;
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
        #4;
        for (int b = 0; b < 4; b++) exp_busy[b] = (cnt_m[b] != 0);
        chk($sformatf("stall@%0d", cycnt), {15'd0, bus.stall}, {15'd0, exp_stall});
        chk($sformatf("err@%0d", cycnt), {15'd0, bus.err}, {15'd0, exp_err});
        chk($sformatf("busy@%0d", cycnt), {12'd0, bus.busy}, {12'd0, exp_busy});
        if (sb.size() > 0 && sb[0].cyc == cycnt) begin
            chk($sformatf("dv@%0d", cycnt), {15'd0, bus.data_valid}, 16'd1);
            chk($sformatf("dout@%0d", cycnt), bus.data_out, sb[0].d);
            void'(sb.pop_front());
        end else begin
            chk($sformatf("dv_idle@%0d", cycnt), {15'd0, bus.data_valid}, 16'd0);
            chk($sformatf("dout_idle@%0d", cycnt), bus.data_out, 16'h0000);
        end
        acc = (r | w) && !exp_stall && !exp_err;
        bk  = int'(a[2:1]);
        idx = int'(a[8:1]);
        for (int b = 0; b < 4; b++) if (cnt_m[b] > 0) cnt_m[b]--;
        if (acc) begin
            cnt_m[bk] = 3;
            if (w) mem_m[idx] = d;
            else   sb.push_back('{cyc: cycnt + 2, d: mem_m[idx]});
        end
        @(posedge clk);
        #1;
        cycnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; cycnt = 0;
        model_reset();
        rst = 1'b0;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000; bus.data_in = 16'h0000;
        #12;
        chk("rst_dout", bus.data_out, 16'h0000);
        chk("rst_dv", {15'd0, bus.data_valid}, 16'd0);
        chk("rst_busy", {12'd0, bus.busy}, 16'd0);
        chk("rst_stall", {15'd0, bus.stall}, 16'd0);
        chk("rst_err", {15'd0, bus.err}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Read burst across all four banks right after reset: zeros, no stalls.
        cyc(1, 0, 16'h0000, 16'h0, 0, 0);
        cyc(1, 0, 16'h0002, 16'h0, 0, 0);
        cyc(1, 0, 16'h0004, 16'h0, 0, 0);
        cyc(1, 0, 16'h0006, 16'h0, 0, 0);
        idle(4);

        // Write burst then read burst back.
        cyc(0, 1, 16'h0010, 16'hA5A0, 0, 0);
        cyc(0, 1, 16'h0012, 16'hA5A1, 0, 0);
        cyc(0, 1, 16'h0014, 16'hA5A2, 0, 0);
        cyc(0, 1, 16'h0016, 16'hA5A3, 0, 0);
        cyc(1, 0, 16'h0010, 16'h0, 0, 0);
        cyc(1, 0, 16'h0012, 16'h0, 0, 0);
        cyc(1, 0, 16'h0014, 16'h0, 0, 0);
        cyc(1, 0, 16'h0016, 16'h0, 0, 0);
        idle(4);

        // Same-bank conflict: read of 0x0028 stalls three cycles after a bank-0 write.
        cyc(0, 1, 16'h0028, 16'hBEEF, 0, 0);
        idle(4);
        cyc(0, 1, 16'h0020, 16'h1111, 0, 0);
        cyc(1, 0, 16'h0028, 16'h0, 1, 0);
        cyc(1, 0, 16'h0028, 16'h0, 1, 0);
        cyc(1, 0, 16'h0028, 16'h0, 1, 0);
        cyc(1, 0, 16'h0028, 16'h0, 0, 0);
        idle(4);

        // Malformed requests, including err winning over stall on a busy bank.
        cyc(1, 1, 16'h0004, 16'h0, 0, 1);
        cyc(1, 0, 16'h0003, 16'h0, 0, 1);
        idle(3);
        cyc(1, 0, 16'h0008, 16'h0, 0, 0);
        cyc(1, 1, 16'h0008, 16'h0, 0, 1);
        cyc(0, 1, 16'h0009, 16'h0, 0, 1);
        idle(4);

        // Reset in flight drops the pending read and clears memory.
        cyc(0, 1, 16'h0030, 16'hCAFE, 0, 0);
        idle(4);
        cyc(1, 0, 16'h0030, 16'h0, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {12'd0, bus.busy}, 16'd0);
        chk("midrst_dv", {15'd0, bus.data_valid}, 16'd0);
        model_reset();
        bus.rd = 1'b0; bus.wr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("inrst_dv", {15'd0, bus.data_valid}, 16'd0);
        rst = 1'b1;
        idle(3);
        cyc(1, 0, 16'h0030, 16'h0, 0, 0);
        idle(3);

        // Address wrap: 0x0202 aliases 0x0002.
        cyc(0, 1, 16'h0202, 16'h1234, 0, 0);
        idle(4);
        cyc(1, 0, 16'h0002, 16'h0, 0, 0);
        idle(3);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
